// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 inverse cipher core.
//
// Contents:
//   BLK_W / NR      block width and number of rounds
//   state_t + ST_*  FSM encoding used by aes_inv_cipher_core
//   INV_SBOX        inverse S-box lookup table
//   IMC_COEF        first row of the InvMixColumns circulant matrix
//   xtime / gmul    GF(2^8) arithmetic, reduction polynomial 0x11b
//   bidx            byte index of state element s[r][c] (row-major, 4r+c)
package aes_pkg;

  localparam int         BLK_W = 128;
  localparam logic [3:0] NR    = 4'd10;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ROUND = 2'd1;
  localparam state_t ST_FINAL = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  localparam logic [7:0] INV_SBOX [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Row r of the InvMixColumns matrix is this row rotated right by r.
  localparam logic [7:0] IMC_COEF [0:3] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic int unsigned bidx(input int unsigned r, input int unsigned c);
    return 4 * r + c;
  endfunction

endpackage

// File: rtl/inv_sub_bytes.sv
// InvSubBytes: sixteen parallel inverse S-box lookups.
//
// Ports:
//   data_i  128-bit state in, byte i at bits [8i+7:8i]
//   data_o  128-bit state out, each byte replaced by INV_SBOX[byte]
module inv_sub_bytes
  import aes_pkg::*;
(
  input  logic [BLK_W-1:0] data_i,
  output logic [BLK_W-1:0] data_o
);

  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign data_o[8*i +: 8] = INV_SBOX[data_i[8*i +: 8]];
  end

endmodule

// File: rtl/aes_inv_cipher_core.sv
// Iterative AES-128 inverse cipher, one round per clock.
// The round key for the current step is requested through rk_idx and must be
// presented on rk combinationally in the same cycle.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   in_valid / in_ready  ciphertext handshake, inp carries the block
//   rk_idx / rk          round-key request index (0..10) and key value
//   out_valid/out_ready  plaintext handshake, res carries the block
// Byte i of any 128-bit bus sits at bits [8i+7:8i]; s[r][c] is byte 4r+c.
//
// Build option AES_INV_PIPE_ACCEPT_EN: when defined, a new block may be
// accepted in DONE in the same cycle the result is retired (11-cycle
// throughput). When undefined, DONE always passes through IDLE first.
module aes_inv_cipher_core
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] inp,
  output logic [3:0]       rk_idx,
  input  logic [BLK_W-1:0] rk,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] res
);

  state_t           fsm_q, fsm_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [BLK_W-1:0] state_q, state_d;

  logic [BLK_W-1:0] shifted, subbed, keyed, mixed;
  logic             accept;

  // InvShiftRows: row r rotates right by r byte positions.
  for (genvar r = 0; r < 4; r++) begin : g_isr_row
    for (genvar c = 0; c < 4; c++) begin : g_isr_col
      assign shifted[8*bidx(r, c) +: 8] = state_q[8*bidx(r, (c + 4 - r) % 4) +: 8];
    end
  end

  inv_sub_bytes u_inv_sub_bytes (
    .data_i (shifted),
    .data_o (subbed)
  );

  assign keyed = subbed ^ rk;

  // InvMixColumns on the key-added state; each column is s[0..3][c].
  for (genvar c = 0; c < 4; c++) begin : g_imc_col
    for (genvar r = 0; r < 4; r++) begin : g_imc_row
      assign mixed[8*bidx(r, c) +: 8] =
          gmul(IMC_COEF[(4 - r) % 4], keyed[8*bidx(0, c) +: 8]) ^
          gmul(IMC_COEF[(5 - r) % 4], keyed[8*bidx(1, c) +: 8]) ^
          gmul(IMC_COEF[(6 - r) % 4], keyed[8*bidx(2, c) +: 8]) ^
          gmul(IMC_COEF[(7 - r) % 4], keyed[8*bidx(3, c) +: 8]);
    end
  end

  // Reset masks in_ready so nothing is accepted during the reset cycle.
`ifdef AES_INV_PIPE_ACCEPT_EN
  assign in_ready = !rst && ((fsm_q == ST_IDLE) || ((fsm_q == ST_DONE) && out_ready));
`else
  assign in_ready = !rst && (fsm_q == ST_IDLE);
`endif

  assign accept    = in_valid && in_ready;
  assign out_valid = (fsm_q == ST_DONE);
  assign res       = state_q;

  // Round-key request: the initial AddRoundKey uses key 10, rounds count down.
  always_comb begin
    rk_idx = NR;
    case (fsm_q)
      ST_IDLE:  rk_idx = NR;
      ST_ROUND: rk_idx = cnt_q;
      ST_FINAL: rk_idx = 4'd0;
`ifdef AES_INV_PIPE_ACCEPT_EN
      ST_DONE:  rk_idx = (out_ready && in_valid) ? NR : 4'd0;
`else
      ST_DONE:  rk_idx = 4'd0;
`endif
      default:  rk_idx = NR;
    endcase
  end

  // Next-state logic: the counter holds the round key index of the next ROUND.
  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    case (fsm_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = inp ^ rk;
          cnt_d   = NR - 4'd1;
          fsm_d   = ST_ROUND;
        end
      end
      ST_ROUND: begin
        state_d = mixed;
        cnt_d   = cnt_q - 4'd1;
        if (cnt_q == 4'd1) fsm_d = ST_FINAL;
      end
      ST_FINAL: begin
        state_d = keyed;
        fsm_d   = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) fsm_d = ST_IDLE;
`ifdef AES_INV_PIPE_ACCEPT_EN
        if (accept) begin
          state_d = inp ^ rk;
          cnt_d   = NR - 4'd1;
          fsm_d   = ST_ROUND;
        end
`endif
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset taking priority over handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= ST_IDLE;
      cnt_q   <= 4'd0;
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_core.sv
// Self-checking bench for aes_inv_cipher_core. Expected plaintexts are pushed
// into a queue when a block is issued; a monitor pops and compares whenever
// the core hands out a result. Round keys are expanded by the bench from the
// cipher key and served on rk according to rk_idx.
// Honours AES_INV_PIPE_ACCEPT_EN the same way as the design.
module tb_aes_inv_cipher_core;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] inp;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] res;

`ifdef AES_INV_PIPE_ACCEPT_EN
  localparam bit PIPE    = 1'b1;
  localparam int EXP_GAP = 11;
`else
  localparam bit PIPE    = 1'b0;
  localparam int EXP_GAP = 12;
`endif

  int nChecks = 0;
  int nErrors = 0;

  logic [127:0] schedA [0:10];
  logic [127:0] schedB [0:10];
  bit           keySel;
  logic [127:0] expQ [$];

  logic [127:0] ctA, ptA, ctB, ptB;

  aes_inv_cipher_core dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inp       (inp),
    .rk_idx    (rk_idx),
    .rk        (rk),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res)
  );

  always #5 clk = ~clk;

  // Serve the requested round key from whichever schedule is selected.
  assign rk = (rk_idx > 4'd10) ? 128'd0 : (keySel ? schedB[rk_idx] : schedA[rk_idx]);

  // FIPS byte k (string order) goes to block byte 4(k mod 4)+(k div 4).
  function automatic logic [127:0] fips2blk(input logic [127:0] f);
    logic [127:0] b;
    b = '0;
    for (int k = 0; k < 16; k++)
      b[8*(4*(k%4) + k/4) +: 8] = f[127-8*k -: 8];
    return b;
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // Forward S-box from first principles: GF inverse then affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    logic [7:0] v8;
    inv = 8'h00;
    for (int v = 1; v < 256; v++) begin
      v8 = v[7:0];
      if (a != 8'h00 && gm(a, v8) == 8'h01) inv = v8;
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  task automatic expandKey(input logic [127:0] key, input bit which);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        t = t ^ {rcon, 24'h0};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) begin
      if (which) schedB[r] = fips2blk({w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
      else       schedA[r] = fips2blk({w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
    end
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Offer a block in IDLE (or wherever in_ready is already high).
  task automatic applyStimulus(input logic [127:0] ct, input logic [127:0] pt);
    int waitCnt;
    waitCnt = 0;
    while (!in_ready && waitCnt < 30) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("ready_before_issue", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b1;
    inp      = ct;
    expQ.push_back(pt);
    @(negedge clk);
    checkOutput("accept_ready", in_ready, 1);
    checkOutput("accept_rk_idx", rk_idx, 10);
  endtask

  // Walk the rounds after acceptance; optionally keep junk on inp meanwhile.
  task automatic traceRounds(input bit junk, input int steps, input logic [127:0] ct);
    for (int k = 1; k <= steps; k++) begin
      @(posedge clk); #1;
      in_valid = junk && (k <= 10);
      if (junk) inp = ~ct ^ 128'(k);
      @(negedge clk);
      if (k <= 10) begin
        checkOutput("rk_idx_trace", rk_idx, 128'(10 - k));
        checkOutput("busy_no_valid", out_valid, 0);
      end else begin
        checkOutput("latency_valid", out_valid, 1);
        checkOutput("done_rk_idx", rk_idx, 0);
        checkOutput("done_in_ready", in_ready, PIPE ? out_ready : 1'b0);
      end
    end
  endtask

  task automatic expectIdle();
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("idle_valid", out_valid, 0);
    checkOutput("idle_ready", in_ready, 1);
  endtask

  // Scoreboard monitor: compare every retired result against the queue head.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (expQ.size() == 0) checkOutput("unexpected_output", 1, 0);
      else                  checkOutput("plaintext", res, expQ.pop_front());
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  gap;
    bit  accepted;
    bit  accAtDone;
    rst       = 1'b1;
    in_valid  = 1'b0;
    inp       = '0;
    out_ready = 1'b1;
    keySel    = 1'b0;

    ctA = fips2blk(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    ptA = fips2blk(128'h00112233445566778899aabbccddeeff);
    ctB = fips2blk(128'h3925841d02dc09fbdc118597196a0b32);
    ptB = fips2blk(128'h3243f6a8885a308d313198a2e0370734);
    expandKey(128'h000102030405060708090a0b0c0d0e0f, 1'b0);
    expandKey(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1);

    // Reset state
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("in_ready_in_reset", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_res", res, 0);
    checkOutput("reset_rk_idx", rk_idx, 10);
    checkOutput("reset_in_ready", in_ready, 1);

    // FIPS-197 C.1 vector with rk_idx trace and latency
    $display("[TB] block A basic");
    keySel = 1'b0;
    applyStimulus(ctA, ptA);
    traceRounds(1'b0, 11, ctA);
    expectIdle();

    // Backpressure: hold out_ready low five cycles
    $display("[TB] block B backpressure");
    out_ready = 1'b0;
    keySel    = 1'b1;
    applyStimulus(ctB, ptB);
    traceRounds(1'b0, 11, ctB);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("hold_valid", out_valid, 1);
      checkOutput("hold_res", res, ptB);
      checkOutput("hold_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    expectIdle();

    // in_valid held with junk data while busy
    $display("[TB] block A with busy in_valid");
    keySel = 1'b0;
    applyStimulus(ctA, ptA);
    traceRounds(1'b1, 11, ctA);
    expectIdle();

    // Reset during the fifth ROUND cycle, then recover
    $display("[TB] reset mid-flight");
    keySel = 1'b1;
    applyStimulus(ctB, ptB);
    traceRounds(1'b0, 4, ctB);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midreset_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    void'(expQ.pop_back());
    @(negedge clk);
    checkOutput("midreset_out_valid", out_valid, 0);
    checkOutput("midreset_in_ready_after", in_ready, 1);
    checkOutput("midreset_rk_idx", rk_idx, 10);
    checkOutput("midreset_res", res, 0);
    applyStimulus(ctB, ptB);
    traceRounds(1'b0, 11, ctB);
    expectIdle();

    // Back-to-back blocks with out_ready always high
    $display("[TB] back-to-back");
    keySel = 1'b0;
    applyStimulus(ctA, ptA);
    traceRounds(1'b0, 10, ctA);
    @(posedge clk); #1;
    keySel   = 1'b1;
    in_valid = 1'b1;
    inp      = ctB;
    expQ.push_back(ptB);
    @(negedge clk);
    checkOutput("b2b_first_valid", out_valid, 1);
    accAtDone = in_ready && in_valid;
    checkOutput("b2b_accept_in_done", accAtDone, PIPE);
    accepted = accAtDone;
    gap = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (accepted) in_valid = 1'b0;
      @(negedge clk);
      if (!accepted && in_ready && in_valid) accepted = 1'b1;
      if (out_valid) begin
        gap = n;
        break;
      end
    end
    checkOutput("b2b_gap", gap, EXP_GAP);
    expectIdle();

    repeat (3) @(negedge clk);
    checkOutput("queue_empty", expQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
